// File: rtl/dshot_pkg.sv
// Shared constants, FSM state type and CRC helper for the DShot receiver.
// Optional command decode is enabled with the DSHOT_RX_CMD_EN macro.
package dshot_pkg;

   localparam int FRAME_BITS = 16;
   localparam int THR_W      = 11;
   localparam int CRC_W      = 4;
   localparam int CMD_W      = 6;
   localparam int CMD_MAX    = 47;

   typedef enum logic [2:0] {
      ST_RESYNC,
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_CHECK
   } rx_state_t;

   // DShot checksum: XOR of the three nibbles of the 12-bit payload
   function automatic logic [CRC_W-1:0] dshot_crc(input logic [11:0] v);
      logic [11:0] x;
      x = v ^ (v >> 4) ^ (v >> 8);
      return x[CRC_W-1:0];
   endfunction

endpackage

// File: rtl/dshot_rx_channel.sv
// Single-line DShot receiver: input synchroniser, pulse-width bit decoder,
// CRC check, registered outputs and failsafe timeout.
// With DSHOT_RX_CMD_EN defined, payload values 1..47 are routed to cmd/cmd_valid.
module dshot_rx_channel
   import dshot_pkg::*;
#(
   parameter int CLK_HZ      = 16000000,
   parameter int DSHOT_RATE  = 150000,
   parameter int TIMEOUT_CYC = 1600000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             line,
   output logic [THR_W-1:0] throttle,
   output logic             telem_req,
   output logic             frame_valid,
   output logic             failsafe,
   output logic             crc_err
`ifdef DSHOT_RX_CMD_EN
   ,
   output logic [CMD_W-1:0] cmd,
   output logic             cmd_valid
`endif
);

   localparam int BIT_CYC  = CLK_HZ / DSHOT_RATE;
   localparam int THRESH   = BIT_CYC / 2;
   localparam int MIN_HIGH = BIT_CYC / 8;
   localparam int GAP_CYC  = 2 * BIT_CYC;
   localparam int CNT_W    = $clog2(GAP_CYC + 2);
   localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]            sync_q;
   logic                  line_s;
   logic                  line_d;
   logic                  rise;
   logic                  fall;
   rx_state_t             state;
   logic [CNT_W-1:0]      cnt;
   logic [4:0]            bit_idx;
   logic [FRAME_BITS-1:0] frame;
   logic [TO_W-1:0]       to_cnt;
   logic                  crc_ok;
   logic                  chk_good;
   logic                  chk_bad;
   logic [THR_W-1:0]      frm_thr;
   logic                  is_cmd;

   // Two-flop synchroniser plus a delayed copy for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         line_d <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value; blocking would collapse the chain
         sync_q <= {sync_q[0], line};
         line_d <= sync_q[1];
      end
   end

   assign line_s = sync_q[1];
   assign rise   = line_s & ~line_d;
   assign fall   = ~line_s & line_d;

   // Bit framing FSM: measures high time of each pulse and assembles the frame MSB first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_RESYNC;
         cnt     <= '0;
         bit_idx <= '0;
         frame   <= '0;
      end else begin
         case (state)
            ST_RESYNC: begin
               bit_idx <= '0;
               if (line_s) begin
                  cnt <= '0;
               end else if (cnt == CNT_W'(GAP_CYC - 1)) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_IDLE: begin
               bit_idx <= '0;
               if (rise) begin
                  cnt   <= '0;
                  state <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (fall) begin
                  cnt <= '0;
                  if (cnt < CNT_W'(MIN_HIGH)) begin
                     state <= ST_RESYNC;
                  end else begin
                     frame   <= {frame[FRAME_BITS-2:0], (cnt > CNT_W'(THRESH))};
                     bit_idx <= bit_idx + 5'd1;
                     state   <= (bit_idx == 5'(FRAME_BITS - 1)) ? ST_CHECK : ST_LOW;
                  end
               end else if (cnt > CNT_W'(BIT_CYC)) begin
                  cnt   <= '0;
                  state <= ST_RESYNC;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_LOW: begin
               if (rise) begin
                  cnt   <= '0;
                  state <= ST_HIGH;
               end else if (cnt > CNT_W'(GAP_CYC)) begin
                  // truncated frame: dropped without counting as a CRC error
                  cnt   <= '0;
                  state <= ST_RESYNC;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_CHECK: begin
               cnt   <= '0;
               state <= ST_RESYNC;
            end
            default: begin
               cnt   <= '0;
               state <= ST_RESYNC;
            end
         endcase
      end
   end

   assign crc_ok   = (dshot_crc(frame[FRAME_BITS-1:CRC_W]) == frame[CRC_W-1:0]);
   assign chk_good = (state == ST_CHECK) && crc_ok;
   assign chk_bad  = (state == ST_CHECK) && !crc_ok;
   assign frm_thr  = frame[FRAME_BITS-1:FRAME_BITS-THR_W];
   assign is_cmd   = (frm_thr != '0) && (frm_thr <= THR_W'(CMD_MAX));

   // Output registers and failsafe timeout; a good frame reloads the timeout counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         throttle    <= '0;
         telem_req   <= 1'b0;
         frame_valid <= 1'b0;
         failsafe    <= 1'b1;
         crc_err     <= 1'b0;
         to_cnt      <= TO_W'(TIMEOUT_CYC);
`ifdef DSHOT_RX_CMD_EN
         cmd         <= '0;
         cmd_valid   <= 1'b0;
`endif
      end else begin
         frame_valid <= 1'b0;
         crc_err     <= chk_bad;
`ifdef DSHOT_RX_CMD_EN
         cmd_valid   <= 1'b0;
`endif
         if (chk_good) begin
            to_cnt <= '0;
`ifdef DSHOT_RX_CMD_EN
            if (is_cmd) begin
               cmd       <= frm_thr[CMD_W-1:0];
               cmd_valid <= 1'b1;
            end else begin
               throttle    <= frm_thr;
               telem_req   <= frame[CRC_W];
               frame_valid <= 1'b1;
               failsafe    <= 1'b0;
            end
`else
            // command range has no meaning here, so it reads as zero throttle
            throttle    <= is_cmd ? '0 : frm_thr;
            telem_req   <= frame[CRC_W];
            frame_valid <= 1'b1;
            failsafe    <= 1'b0;
`endif
         end else if (to_cnt < TO_W'(TIMEOUT_CYC)) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
               failsafe  <= 1'b1;
               throttle  <= '0;
               telem_req <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/dshot_rx_multi.sv
// N-channel DShot receiver: one dshot_rx_channel per input line plus a shared
// saturating CRC-error counter. DSHOT_RX_CMD_EN adds the cmd/cmd_valid outputs.
module dshot_rx_multi
   import dshot_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CLK_HZ      = 16000000,
   parameter int DSHOT_RATE  = 150000,
   parameter int TIMEOUT_CYC = 1600000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       dshot_in,
   output logic [NUM_CH*THR_W-1:0] throttle,
   output logic [NUM_CH-1:0]       telem_req,
   output logic [NUM_CH-1:0]       frame_valid,
   output logic [NUM_CH-1:0]       failsafe,
   output logic [7:0]              crc_err_cnt
`ifdef DSHOT_RX_CMD_EN
   ,
   output logic [NUM_CH*CMD_W-1:0] cmd,
   output logic [NUM_CH-1:0]       cmd_valid
`endif
);

   logic [NUM_CH-1:0] crc_err;
   logic [3:0]        err_sum;
   logic [8:0]        cnt_sum;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      dshot_rx_channel #(
         .CLK_HZ      (CLK_HZ),
         .DSHOT_RATE  (DSHOT_RATE),
         .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .line        (dshot_in[i]),
         .throttle    (throttle[THR_W*i +: THR_W]),
         .telem_req   (telem_req[i]),
         .frame_valid (frame_valid[i]),
         .failsafe    (failsafe[i]),
         .crc_err     (crc_err[i])
`ifdef DSHOT_RX_CMD_EN
         ,
         .cmd         (cmd[CMD_W*i +: CMD_W]),
         .cmd_valid   (cmd_valid[i])
`endif
      );
   end

   // Popcount of this cycle's error requests and the widened sum for saturation
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch
      err_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         err_sum = err_sum + {3'b000, crc_err[i]};
      end
      cnt_sum = {1'b0, crc_err_cnt} + {5'b00000, err_sum};
   end

   // Saturating CRC-error counter shared by all channels
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_err_cnt <= '0;
      end else begin
         crc_err_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
      end
   end

endmodule

// File: tb/tb_dshot_rx_multi.sv
// Scoreboard bench for dshot_rx_multi, run at DShot600 timing (26 clk per bit)
// with a short timeout. Build with +define+DSHOT_RX_CMD_EN for the command variant.
module tb_dshot_rx_multi;

   localparam int NUM_CH      = 4;
   localparam int CLK_HZ      = 16000000;
   localparam int DSHOT_RATE  = 600000;
   localparam int TIMEOUT_CYC = 3000;
   localparam int BIT_CYC     = CLK_HZ / DSHOT_RATE;  // 26
   localparam int ONE_HI      = 20;                   // '1' = 20 high / 6 low
   localparam int ZERO_HI     = 10;                   // '0' = 10 high / 16 low
   localparam int IDLE_CYC    = 80;                   // line-low gap before each frame

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_CH-1:0]    dshot_in;
   logic [NUM_CH*11-1:0] throttle;
   logic [NUM_CH-1:0]    telem_req;
   logic [NUM_CH-1:0]    frame_valid;
   logic [NUM_CH-1:0]    failsafe;
   logic [7:0]           crc_err_cnt;
   logic [NUM_CH-1:0]    cmd_valid_w;
   logic [NUM_CH*6-1:0]  cmd_w;

   dshot_rx_multi #(
      .NUM_CH      (NUM_CH),
      .CLK_HZ      (CLK_HZ),
      .DSHOT_RATE  (DSHOT_RATE),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dshot_in    (dshot_in),
      .throttle    (throttle),
      .telem_req   (telem_req),
      .frame_valid (frame_valid),
      .failsafe    (failsafe),
      .crc_err_cnt (crc_err_cnt)
`ifdef DSHOT_RX_CMD_EN
      ,
      .cmd         (cmd_w),
      .cmd_valid   (cmd_valid_w)
`endif
   );

`ifndef DSHOT_RX_CMD_EN
   assign cmd_valid_w = '0;
   assign cmd_w       = '0;
`endif

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         ch;
      logic       is_cmd;
      logic [10:0] thr;
      logic       telem;
      logic [5:0] cmd;
      longint     due;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] tx_word  [NUM_CH];
   int          exp_kind [NUM_CH];   // 0 none, 1 throttle frame, 2 command
   logic [10:0] exp_thr  [NUM_CH];
   logic        exp_tel  [NUM_CH];
   logic [5:0]  exp_cmd  [NUM_CH];
   longint      last_due [NUM_CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_exp();
      for (int ch = 0; ch < NUM_CH; ch++) exp_kind[ch] = 0;
   endtask

   function automatic logic [10:0] thr_of(input int ch);
      return throttle[11*ch +: 11];
   endfunction

   // Drive the first nbits of tx_word on every masked channel; push the expected
   // response at the moment of the last falling edge (outputs due 4 cycles later).
   task automatic send(input logic [NUM_CH-1:0] mask, input int nbits);
      logic bv;
      int   hi;
      exp_t e;
      repeat (IDLE_CYC) @(negedge clk);
      for (int b = 0; b < nbits; b++) begin
         for (int j = 0; j < BIT_CYC; j++) begin
            @(negedge clk);
            for (int ch = 0; ch < NUM_CH; ch++) begin
               if (mask[ch]) begin
                  bv = tx_word[ch][15-b];
                  hi = bv ? ONE_HI : ZERO_HI;
                  dshot_in[ch] = (j < hi);
                  if (b == 15 && j == hi && exp_kind[ch] != 0) begin
                     e.ch     = ch;
                     e.is_cmd = (exp_kind[ch] == 2);
                     e.thr    = exp_thr[ch];
                     e.telem  = exp_tel[ch];
                     e.cmd    = exp_cmd[ch];
                     e.due    = cyc + 4;
                     last_due[ch] = cyc + 4;
                     exp_q.push_back(e);
                  end
               end
            end
         end
      end
   endtask

   // Monitor: pops the matching expectation whenever a channel pulses
   initial begin : monitor
      int   idx;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
               if (frame_valid[ch] || cmd_valid_w[ch]) begin
                  idx = -1;
                  for (int i = 0; i < exp_q.size(); i++) begin
                     if (idx < 0 && exp_q[i].ch == ch) idx = i;
                  end
                  if (idx < 0) begin
                     check($sformatf("spurious_pulse_ch%0d", ch),
                           32'(frame_valid[ch] | cmd_valid_w[ch]), 32'd0);
                  end else begin
                     e = exp_q[idx];
                     exp_q.delete(idx);
                     check($sformatf("latency_ch%0d", ch), 32'(cyc), 32'(e.due));
                     check($sformatf("frame_valid_ch%0d", ch), 32'(frame_valid[ch]),
                           e.is_cmd ? 32'd0 : 32'd1);
                     check($sformatf("cmd_valid_ch%0d", ch), 32'(cmd_valid_w[ch]),
                           e.is_cmd ? 32'd1 : 32'd0);
                     check($sformatf("throttle_ch%0d", ch), 32'(thr_of(ch)), 32'(e.thr));
                     if (e.is_cmd) begin
                        check($sformatf("cmd_ch%0d", ch), 32'(cmd_w[6*ch +: 6]), 32'(e.cmd));
                     end else begin
                        check($sformatf("telem_ch%0d", ch), 32'(telem_req[ch]), 32'(e.telem));
                        check($sformatf("failsafe_ch%0d", ch), 32'(failsafe[ch]), 32'd0);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #(4000000);
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      longint a;
      rst      = 1'b1;
      dshot_in = '0;
      clear_exp();
      wait_cycles(5);

      // reset state
      check("rst_throttle", throttle, 0);
      check("rst_telem", 32'(telem_req), 0);
      check("rst_frame_valid", 32'(frame_valid), 0);
      check("rst_failsafe", 32'(failsafe), 32'hF);
      check("rst_crc_cnt", 32'(crc_err_cnt), 0);
      rst = 1'b0;

      // 0x82C6 on ch0 -> throttle 1046, telem 0
      tx_word[0] = 16'h82C6; exp_kind[0] = 1; exp_thr[0] = 11'd1046; exp_tel[0] = 1'b0;
      send(4'b0001, 16);
      wait_cycles(10);
      check("pending_ch0_frame", 32'(exp_q.size()), 0);
      check("failsafe0_after_frame", 32'(failsafe[0]), 0);
      clear_exp();

      // 0x82C7 on ch1: bad CRC, nothing published, error count 1
      tx_word[1] = 16'h82C7;
      send(4'b0010, 16);
      wait_cycles(10);
      check("crc_cnt_after_bad", 32'(crc_err_cnt), 1);
      check("thr1_after_bad", 32'(thr_of(1)), 0);
      check("thr0_held", 32'(thr_of(0)), 1046);

      // simultaneous good frames on all channels
      tx_word[0] = 16'h82C6; exp_kind[0] = 1; exp_thr[0] = 11'd1046; exp_tel[0] = 1'b0;
      tx_word[1] = 16'h0617; exp_kind[1] = 1; exp_thr[1] = 11'd48;   exp_tel[1] = 1'b1;
      tx_word[2] = 16'hFFEE; exp_kind[2] = 1; exp_thr[2] = 11'd2047; exp_tel[2] = 1'b0;
      tx_word[3] = 16'h82C6; exp_kind[3] = 1; exp_thr[3] = 11'd1046; exp_tel[3] = 1'b0;
      send(4'b1111, 16);
      wait_cycles(10);
      check("pending_all_frames", 32'(exp_q.size()), 0);
      check("crc_cnt_after_good", 32'(crc_err_cnt), 1);
      clear_exp();

      // payload value 10 on ch3 (0x0145)
      tx_word[3] = 16'h0145;
`ifdef DSHOT_RX_CMD_EN
      exp_kind[3] = 2; exp_cmd[3] = 6'd10; exp_thr[3] = 11'd1046; exp_tel[3] = 1'b0;
`else
      exp_kind[3] = 1; exp_cmd[3] = 6'd0;  exp_thr[3] = 11'd0;    exp_tel[3] = 1'b0;
`endif
      send(4'b1000, 16);
      wait_cycles(10);
      check("pending_value10", 32'(exp_q.size()), 0);
`ifdef DSHOT_RX_CMD_EN
      check("thr3_after_cmd", 32'(thr_of(3)), 1046);
`else
      check("thr3_after_value10", 32'(thr_of(3)), 0);
`endif
      clear_exp();

      // timeout on ch2: good frame, then silence for TIMEOUT_CYC cycles
      tx_word[2] = 16'h0617; exp_kind[2] = 1; exp_thr[2] = 11'd48; exp_tel[2] = 1'b1;
      send(4'b0100, 16);
      a = last_due[2];
      while (cyc < a + TIMEOUT_CYC - 1) @(negedge clk);
      check("fs2_before_timeout", 32'(failsafe[2]), 0);
      check("thr2_before_timeout", 32'(thr_of(2)), 48);
      @(negedge clk);
      check("fs2_at_timeout", 32'(failsafe[2]), 1);
      check("thr2_at_timeout", 32'(thr_of(2)), 0);
      check("telem2_at_timeout", 32'(telem_req[2]), 0);
      tx_word[2] = 16'hFFEE; exp_kind[2] = 1; exp_thr[2] = 11'd2047; exp_tel[2] = 1'b0;
      send(4'b0100, 16);
      wait_cycles(10);
      check("pending_ch2_recover", 32'(exp_q.size()), 0);
      check("fs2_recovered", 32'(failsafe[2]), 0);
      clear_exp();

      // CRC error counter saturation: 1 + 63*4 = 253, then 255 and held
      for (int ch = 0; ch < NUM_CH; ch++) tx_word[ch] = 16'h82C7;
      repeat (63) send(4'b1111, 16);
      wait_cycles(10);
      check("crc_cnt_253", 32'(crc_err_cnt), 253);
      send(4'b1111, 16);
      wait_cycles(10);
      check("crc_cnt_sat", 32'(crc_err_cnt), 255);
      send(4'b1111, 16);
      wait_cycles(10);
      check("crc_cnt_held", 32'(crc_err_cnt), 255);

      // load every channel so the reset has something to clear
      tx_word[0] = 16'h82C6; exp_kind[0] = 1; exp_thr[0] = 11'd1046; exp_tel[0] = 1'b0;
      tx_word[1] = 16'h0617; exp_kind[1] = 1; exp_thr[1] = 11'd48;   exp_tel[1] = 1'b1;
      tx_word[2] = 16'hFFEE; exp_kind[2] = 1; exp_thr[2] = 11'd2047; exp_tel[2] = 1'b0;
      tx_word[3] = 16'h82C6; exp_kind[3] = 1; exp_thr[3] = 11'd1046; exp_tel[3] = 1'b0;
      send(4'b1111, 16);
      wait_cycles(10);
      check("pending_preload", 32'(exp_q.size()), 0);
      check("fs_all_clear", 32'(failsafe), 0);
      clear_exp();

      // short glitch, then reset in the middle of a frame after 8 bits
      wait_cycles(IDLE_CYC);
      dshot_in[0] = 1'b1;
      wait_cycles(2);
      dshot_in[0] = 1'b0;
      tx_word[0] = 16'h82C6;
      send(4'b0001, 8);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_throttle", throttle, 0);
      check("midrst_telem", 32'(telem_req), 0);
      check("midrst_frame_valid", 32'(frame_valid), 0);
      check("midrst_failsafe", 32'(failsafe), 32'hF);
      check("midrst_crc_cnt", 32'(crc_err_cnt), 0);
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(40);
      check("post_rst_thr0", 32'(thr_of(0)), 0);

      // full good frame after the gap is accepted
      tx_word[0] = 16'h82C6; exp_kind[0] = 1; exp_thr[0] = 11'd1046; exp_tel[0] = 1'b0;
      send(4'b0001, 16);
      wait_cycles(10);
      check("pending_after_rst", 32'(exp_q.size()), 0);
      check("thr0_after_rst", 32'(thr_of(0)), 1046);
      check("fs_after_rst", 32'(failsafe), 32'hE);
      clear_exp();

      wait_cycles(20);
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dshot_rx_multi.md
Name: dshot_rx_multi

Overview:
- Parametrised N-channel DShot receiver.
- Oversamples each DShot input line, decodes 16-bit frames and checks the 4-bit CRC.
- Per channel it publishes throttle, telemetry-request bit, frame-valid strobe and failsafe flag.
- Feeds the per-channel pwmout and blctrlHandler speed buses; replaces the single-channel speedhandler.

Parameters:
- NUM_CH, 4, number of independent DShot input channels (1..8)
- CLK_HZ, 16000000, system clock frequency in Hz
- DSHOT_RATE, 150000, DShot bit rate in bit/s
- TIMEOUT_CYC, 1600000, cycles without a valid frame before failsafe (100 ms at 16 MHz)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- dshot_in  in  NUM_CH  raw DShot lines, bit i = channel i, asynchronous to clk
- throttle  out  NUM_CH*11  flat throttle bus, channel i at [11*i+10:11*i]
- telem_req  out  NUM_CH  telemetry bit of the last valid frame
- frame_valid  out  NUM_CH  1-cycle pulse per accepted frame
- failsafe  out  NUM_CH  1 = no valid frame within TIMEOUT_CYC
- crc_err_cnt  out  8  saturating count of CRC-failed frames, all channels combined

Behaviour:
- Derived constants:
  - BIT_CYC = CLK_HZ/DSHOT_RATE (106 at defaults)
  - THRESH = BIT_CYC/2 (53)
  - MIN_HIGH = BIT_CYC/8 (13)
  - GAP_CYC = 2*BIT_CYC (212)
- Input sync: each dshot_in bit passes through a 2-flop synchroniser; all edges are taken on the synchronised signal.
- Per-channel FSM, reset state RESYNC:
  - RESYNC: wait until the line has been low for GAP_CYC consecutive cycles -> IDLE. A high level restarts the low count.
  - IDLE: on rising edge -> HIGH; clear the high counter.
  - HIGH: count high cycles. On falling edge:
    - count < MIN_HIGH -> RESYNC (glitch).
    - Otherwise shift in bit = (count > THRESH), MSB first, increment bit_idx.
    - bit_idx reaches 16 -> CHECK; else -> LOW.
    - If count exceeds BIT_CYC before the falling edge -> RESYNC.
  - LOW: count low cycles. Rising edge -> HIGH. Low count exceeds GAP_CYC -> RESYNC (truncated frame, silently dropped, not a CRC error).
  - CHECK (1 cycle): v = frame[15:4]; crc = (v ^ v>>4 ^ v>>8) & 4'hF.
    - crc == frame[3:0]: register throttle = frame[15:5], telem_req = frame[4], pulse frame_valid next cycle, reload timeout counter.
    - Mismatch: request a CRC-error increment; outputs are held.
    - Both cases -> RESYNC.
- Latency: outputs and frame_valid update 4 clk cycles after the raw falling edge of bit 16 (2 sync + CHECK + output register).
- Timeout:
  - Per-channel counter reloads on each valid frame.
  - On reaching TIMEOUT_CYC it sets failsafe=1 and forces throttle=0, telem_req=0.
  - The next valid frame clears failsafe in the same cycle throttle updates.
- crc_err_cnt: adds the popcount of simultaneous per-channel error requests in one cycle; saturates at 255 and never wraps.
- Reset (asserted at any time, including mid-frame):
  - throttle=0, telem_req=0, frame_valid=0, failsafe=1, crc_err_cnt=0.
  - All FSMs -> RESYNC; synchronisers cleared.
- Channels are fully independent; simultaneous frames on all channels are all accepted.

Optional Feature:
- Macro: DSHOT_RX_CMD_EN.
- Defined:
  - Adds outputs cmd (NUM_CH*6 bits) and cmd_valid (NUM_CH).
  - A valid frame with throttle value 1..47 loads cmd and pulses cmd_valid instead of frame_valid; throttle is unchanged.
  - The timeout counter still reloads.
- Undefined:
  - Values 1..47 are accepted as throttle 0 and pulse frame_valid.
  - No extra ports.

Decomposition:
- Package dshot_pkg holds:
  - FRAME_BITS=16, THR_W=11, CRC_W=4
  - the FSM state enum
  - function dshot_crc(12-bit) returning 4 bits
- Sub-module dshot_rx_channel: synchroniser, FSM, CRC check and timeout for one line.
- Top instantiates NUM_CH copies via generate and owns the shared crc_err_cnt saturating adder.

Test Plan:
- Frame 0x82C6 on ch0 (throttle 1046, telem 0, '1' = 80 cyc high / 26 low, '0' = 40 high / 66 low) -> throttle[10:0]=1046, frame_valid[0] pulse 4 cycles after last falling edge, failsafe[0]=0.
- Frame 0x82C7 (bad CRC) on ch1 -> no frame_valid, throttle unchanged, crc_err_cnt +1.
- Bad-CRC frames on all 4 channels in the same cycle, with crc_err_cnt=253 -> crc_err_cnt=255 and stays at 255.
- Valid frame on ch2, then idle 1600000 cycles -> failsafe[2]=1 and throttle ch2 = 0; next valid frame -> failsafe[2]=0.
- 10-cycle glitch pulse, then rst asserted mid-frame after 8 bits -> frame dropped, all outputs at reset values; next full valid frame after a 212-cycle low gap accepted.
- With DSHOT_RX_CMD_EN, a frame carrying value 10 -> cmd=10, cmd_valid pulse, throttle unchanged; without the macro, the same frame gives throttle=0 and a frame_valid pulse.
